// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants for the UART command responder.
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - protocol opcodes and reply bytes
//   - sat_inc8: saturating 8-bit increment used by the error counter
package uart_cmd_pkg;

  localparam logic [2:0] S_OP   = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_TX   = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;
  localparam logic [2:0] S_WAIT = 3'd5;

  localparam logic [7:0] OP_W    = 8'h57;
  localparam logic [7:0] OP_R    = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout: inter-byte idle watchdog for a command frame.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   en          frame in progress; counter is held at 0 while low
//   clr         a byte was consumed this cycle; restarts the idle count
//   expire      one-cycle pulse on the TIMEOUT_CYC-th consecutive idle cycle
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  // A consumed byte in the same cycle wins over expiry.
  always_comb begin
    if (en && !clr && (cnt == LAST)) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

  // Idle-cycle counter: zero outside a frame, restarted by each byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || clr || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: byte-level command client of a uart user interface.
//   'W' addr data -> reg[addr] <= data, reply 'K'
//   'R' addr      -> reply reg[addr]
//   other opcode  -> reply '?', err_cnt++
// Ports:
//   clk_50m, rst_n       clock / asynchronous active-low reset
//   rx_rdy, rx_data      received byte valid / value (uart rdy, dout)
//   rx_clr               one-cycle consume pulse (uart rdy_clr)
//   tx_busy              transmitter busy (uart tx_busy)
//   tx_wr_en, tx_data    one-cycle send pulse / byte, held until tx_busy falls
//   regs_q               register bank, reg[i] = regs_q[8*i+7:8*i]
//   err_cnt              saturating count of bad opcodes and frame timeouts
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int NREGS       = 16,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic               clk_50m,
  input  logic               rst_n,
  input  logic               rx_rdy,
  input  logic [7:0]         rx_data,
  output logic               rx_clr,
  input  logic               tx_busy,
  output logic               tx_wr_en,
  output logic [7:0]         tx_data,
  output logic [8*NREGS-1:0] regs_q,
  output logic [7:0]         err_cnt
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [2:0]    state;
  logic          is_write;
  logic [AW-1:0] addr;
  logic [7:0]    reply;
  logic          in_frame;
  logic          consume;
  logic          expire;
  logic [AW-1:0] rx_idx;
  logic [7:0]    rd_byte;

  // Byte acceptance. rx_rdy is still high in the cycle rx_clr is asserted
  // (uart drops rdy one cycle later), so that cycle must not consume again.
  always_comb begin
    in_frame = (state == S_ADDR) || (state == S_DATA);
    if ((state == S_OP || in_frame) && rx_rdy && !rx_clr) begin
      consume = 1'b1;
    end else begin
      consume = 1'b0;
    end
    // Upper address bits are simply dropped (wrap-around addressing).
    rx_idx  = rx_data[AW-1:0];
    rd_byte = regs_q[{rx_idx, 3'b000} +: 8];
  end

  uart_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .en    (in_frame),
    .clr   (consume),
    .expire(expire)
  );

  // Command FSM, register bank, reply path and error counter.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_OP;
      is_write <= 1'b0;
      addr     <= '0;
      reply    <= 8'h00;
      rx_clr   <= 1'b0;
      tx_wr_en <= 1'b0;
      tx_data  <= 8'h00;
      regs_q   <= '0;
      err_cnt  <= 8'h00;
    end else begin
      rx_clr   <= consume;
      tx_wr_en <= 1'b0;
      case (state)
        S_OP: begin
          if (consume) begin
            if (rx_data == OP_W) begin
              is_write <= 1'b1;
              state    <= S_ADDR;
            end else if (rx_data == OP_R) begin
              is_write <= 1'b0;
              state    <= S_ADDR;
            end else begin
              reply   <= RSP_ERR;
              err_cnt <= sat_inc8(err_cnt);
              state   <= S_TX;
            end
          end
        end
        S_ADDR: begin
          if (consume) begin
            addr <= rx_idx;
            if (is_write) begin
              state <= S_DATA;
            end else begin
              reply <= rd_byte;
              state <= S_TX;
            end
          end else if (expire) begin
            err_cnt <= sat_inc8(err_cnt);
            state   <= S_OP;
          end
        end
        S_DATA: begin
          if (consume) begin
            regs_q[{addr, 3'b000} +: 8] <= rx_data;
            reply <= RSP_OK;
            state <= S_TX;
          end else if (expire) begin
            err_cnt <= sat_inc8(err_cnt);
            state   <= S_OP;
          end
        end
        S_TX: begin
          if (!tx_busy) begin
            tx_wr_en <= 1'b1;
            tx_data  <= reply;
            state    <= S_HOLD;
          end
        end
        // tx_busy only rises the cycle after wr_en; skip one cycle before
        // looking at it so the reply is not mistaken for already sent.
        S_HOLD: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!tx_busy) begin
            state <= S_OP;
          end
        end
        default: begin
          state <= S_OP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder with behavioural uart user-side
// models (rdy/rdy_clr handshake, tx_busy after wr_en) and a reply scoreboard.
module tb_uart_cmd_responder;

  localparam int NREGS       = 16;
  localparam int TIMEOUT_CYC = 1000;
  localparam int TXLEN       = 8;

  logic               clk_50m = 1'b0;
  logic               rst_n   = 1'b0;
  logic               rx_rdy  = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_clr;
  logic               tx_busy = 1'b0;
  logic               tx_wr_en;
  logic [7:0]         tx_data;
  logic [8*NREGS-1:0] regs_q;
  logic [7:0]         err_cnt;

  int tests = 0;
  int fails = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] mdl[NREGS];
  int clr_count = 0, tx_count = 0, cyc = 0, last_clr_cyc = 0, last_wr_cyc = 0;
  int busy_left = 0;
  bit tx_start = 1'b0;
  bit unstable = 1'b0;
  bit prev_busy = 1'b0;
  logic [7:0] cap = 8'h00;

  uart_cmd_responder #(.NREGS(NREGS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data),
    .rx_clr  (rx_clr),
    .tx_busy (tx_busy),
    .tx_wr_en(tx_wr_en),
    .tx_data (tx_data),
    .regs_q  (regs_q),
    .err_cnt (err_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8*NREGS-1:0] pack_mdl();
    logic [8*NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[8*i +: 8] = mdl[i];
    return v;
  endfunction

  // uart receive side: hold rdy until rdy_clr is seen, drop it the next edge
  initial forever begin
    @(posedge clk_50m);
    if (rx_rdy && rx_clr) begin
      rx_rdy <= 1'b0;
    end else if (!rx_rdy && rx_q.size() > 0) begin
      rx_data <= rx_q.pop_front();
      rx_rdy  <= 1'b1;
    end
  end

  // uart transmit side: busy rises the cycle after wr_en, lasts TXLEN cycles
  initial forever begin
    @(posedge clk_50m);
    if (tx_start) begin
      tx_start  = 1'b0;
      tx_busy  <= 1'b1;
      busy_left = TXLEN;
    end else if (busy_left > 1) begin
      busy_left--;
    end else if (busy_left == 1) begin
      busy_left = 0;
      tx_busy  <= 1'b0;
    end
  end

  // monitor / scoreboard, sampled on the falling edge
  initial forever begin
    @(negedge clk_50m);
    cyc++;
    if (rx_clr) begin
      clr_count++;
      last_clr_cyc = cyc;
    end
    if (tx_wr_en) begin
      tx_count++;
      last_wr_cyc = cyc;
      cap      = tx_data;
      unstable = 1'b0;
      tx_start = 1'b1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL tx_unexpected: got %0h expected no byte", tx_data);
      end else begin
        check("tx_byte", {120'd0, tx_data}, {120'd0, exp_q.pop_front()});
      end
    end else if (tx_busy && tx_data !== cap) begin
      unstable = 1'b1;
    end
    if (prev_busy && !tx_busy) check("tx_data_stable", {127'd0, unstable}, 128'd0);
    prev_busy = tx_busy;
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(rx_q.size() == 0 && !rx_rdy && exp_q.size() == 0 && !tx_busy &&
             !tx_wr_en && !tx_start) && n < budget) begin
      @(negedge clk_50m);
      n++;
    end
    check("wait_budget", {127'd0, (n >= budget)}, 128'd0);
    repeat (4) @(negedge clk_50m);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    rx_q.push_back(8'h57);
    rx_q.push_back(a);
    rx_q.push_back(d);
    exp_q.push_back(8'h4B);
    mdl[int'(a) % NREGS] = d;
    wait_done(500);
  endtask

  task automatic do_read(input logic [7:0] a);
    rx_q.push_back(8'h52);
    rx_q.push_back(a);
    exp_q.push_back(mdl[int'(a) % NREGS]);
    wait_done(500);
  endtask

  task automatic send_bad(input int count);
    logic [7:0] b;
    for (int i = 0; i < count; i++) begin
      b = 8'(i);
      if (b == 8'h57 || b == 8'h52) b = 8'h01;
      rx_q.push_back(b);
      exp_q.push_back(8'h3F);
    end
    wait_done(20 * count + 100);
  endtask

  initial begin
    int c0, t0, n;
    for (int i = 0; i < NREGS; i++) mdl[i] = 8'h00;

    // reset values
    repeat (3) @(negedge clk_50m);
    check("rst_tx_wr_en", {127'd0, tx_wr_en}, 128'd0);
    check("rst_rx_clr", {127'd0, rx_clr}, 128'd0);
    check("rst_tx_data", {120'd0, tx_data}, 128'd0);
    check("rst_regs", regs_q, 128'd0);
    check("rst_err", {120'd0, err_cnt}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk_50m);

    // write then read back, with read latency
    do_write(8'h03, 8'hA5);
    check("w3_reg", {120'd0, regs_q[31:24]}, {120'd0, 8'hA5});
    check("w3_bank", regs_q, pack_mdl());
    do_read(8'h03);
    check("read_latency", 128'(last_wr_cyc - last_clr_cyc), 128'd1);

    // bad opcode
    rx_q.push_back(8'h00);
    exp_q.push_back(8'h3F);
    wait_done(500);
    check("bad_op_err", {120'd0, err_cnt}, 128'd1);

    // address wrap
    do_write(8'h13, 8'h77);
    check("wrap_reg3", {120'd0, regs_q[31:24]}, {120'd0, 8'h77});
    check("wrap_bank", regs_q, pack_mdl());

    // frame timeout after opcode
    t0 = tx_count;
    rx_q.push_back(8'h52);
    wait_done(500);
    repeat (900) @(negedge clk_50m);
    check("timeout_not_early", {120'd0, err_cnt}, 128'd1);
    repeat (200) @(negedge clk_50m);
    check("timeout_err", {120'd0, err_cnt}, 128'd2);
    check("timeout_no_tx", 128'(tx_count - t0), 128'd0);
    do_read(8'h00);

    // back-to-back reads
    do_write(8'h01, 8'h11);
    do_write(8'h02, 8'h22);
    c0 = clr_count;
    rx_q.push_back(8'h52); rx_q.push_back(8'h01);
    rx_q.push_back(8'h52); rx_q.push_back(8'h02);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    wait_done(500);
    check("b2b_clr_count", 128'(clr_count - c0), 128'd4);

    // reset in the middle of a write frame
    c0 = clr_count;
    t0 = tx_count;
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h05);
    n = 0;
    while (!((clr_count - c0) == 2 && !rx_rdy) && n < 200) begin
      @(negedge clk_50m);
      n++;
    end
    check("midrst_budget", {127'd0, (n >= 200)}, 128'd0);
    @(negedge clk_50m);
    rst_n = 1'b0;
    for (int i = 0; i < NREGS; i++) mdl[i] = 8'h00;
    repeat (3) @(negedge clk_50m);
    check("midrst_regs", regs_q, 128'd0);
    check("midrst_err", {120'd0, err_cnt}, 128'd0);
    check("midrst_wr_en", {127'd0, tx_wr_en}, 128'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_50m);
    check("midrst_no_tx", 128'(tx_count - t0), 128'd0);
    do_write(8'h05, 8'h3C);
    check("post_rst_bank", regs_q, pack_mdl());
    check("post_rst_err", {120'd0, err_cnt}, 128'd0);

    // error counter saturation
    send_bad(254);
    check("err_fe", {120'd0, err_cnt}, {120'd0, 8'hFE});
    send_bad(1);
    check("err_ff", {120'd0, err_cnt}, {120'd0, 8'hFF});
    send_bad(45);
    check("err_sat", {120'd0, err_cnt}, {120'd0, 8'hFF});

    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(20 * 90000);
    fails++;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
